// File: rtl/can_destuff_pkg.sv
// Shared types and default constants for the CAN bit destuffing controller.
package can_destuff_pkg;

    localparam int unsigned STUFF_LEN_DEF = 5;
    localparam int unsigned IDLE_BITS_DEF = 11;

    typedef enum logic [2:0] {
        StInteg,
        StReady,
        StStuff,
        StNostuff,
        StError
    } state_e;

endpackage

// File: rtl/can_bus_idle_det.sv
// Counts consecutive recessive samples, saturating at IDLE_BITS; flags the sample that
// brings (or keeps) the count at IDLE_BITS.
module can_bus_idle_det
    import can_destuff_pkg::*;
#(
    parameter int unsigned IDLE_BITS = IDLE_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_point,
    input  logic rx_bit,
    output logic idle_reached
);

    localparam int unsigned CntW = $clog2(IDLE_BITS + 1);

    logic [CntW-1:0] r_cnt;
    logic            w_sat;

    assign w_sat = (r_cnt == CntW'(IDLE_BITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sample_point) begin
            if (!rx_bit) begin
                r_cnt <= '0;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    // Combinational so the FSM can move on the very sample that completes the count.
    assign idle_reached = sample_point && rx_bit &&
                          (w_sat || (r_cnt == CntW'(IDLE_BITS - 1)));

endmodule

// File: rtl/can_destuff_ctrl.sv
// CAN receive bit destuffer: SOF detection, stuff-bit removal and stuff-error detection.
// Define CAN_DESTUFF_STATS_EN to add the stuff_cnt / err_cnt statistics ports.
module can_destuff_ctrl
    import can_destuff_pkg::*;
#(
    parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
    parameter int unsigned IDLE_BITS = IDLE_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       stuff_en,
    input  logic       frame_end,
    output logic       data_valid,
    output logic       data_bit,
    output logic       sof,
    output logic       remove_pulse,
    output logic       stuff_error,
    output logic       bus_idle
`ifdef CAN_DESTUFF_STATS_EN
    ,
    output logic [7:0] stuff_cnt,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned RunW = $clog2(STUFF_LEN + 1);

    state_e          r_state;
    logic [RunW-1:0] r_run;
    logic            r_prev;
    logic            w_idle_reached;
    logic            w_run_full;

    can_bus_idle_det #(
        .IDLE_BITS (IDLE_BITS)
    ) u_idle_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .idle_reached (w_idle_reached)
    );

    assign w_run_full = (r_run == RunW'(STUFF_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StInteg;
            r_run        <= RunW'(1);
            r_prev       <= 1'b1;
            data_valid   <= 1'b0;
            data_bit     <= 1'b0;
            sof          <= 1'b0;
            remove_pulse <= 1'b0;
            stuff_error  <= 1'b0;
            bus_idle     <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            sof          <= 1'b0;
            remove_pulse <= 1'b0;
            stuff_error  <= 1'b0;
            if (sample_point) begin
                unique case (r_state)
                    StInteg, StError: begin
                        if (w_idle_reached) begin
                            r_state  <= StReady;
                            bus_idle <= 1'b1;
                        end
                    end
                    StReady: begin
                        if (!rx_bit) begin
                            sof        <= 1'b1;
                            data_valid <= 1'b1;
                            data_bit   <= 1'b0;
                            r_run      <= RunW'(1);
                            r_prev     <= 1'b0;
                            r_state    <= StStuff;
                            bus_idle   <= 1'b0;
                        end
                    end
                    StStuff: begin
                        if (stuff_en && w_run_full) begin
                            // Stuff position: frame_end wins over both drop and error.
                            if (frame_end) begin
                                r_state  <= StReady;
                                bus_idle <= 1'b1;
                            end else if (rx_bit != r_prev) begin
                                remove_pulse <= 1'b1;
                                r_run        <= RunW'(1);
                                r_prev       <= rx_bit;
                            end else begin
                                stuff_error <= 1'b1;
                                r_state     <= StError;
                            end
                        end else begin
                            data_valid <= 1'b1;
                            data_bit   <= rx_bit;
                            r_prev     <= rx_bit;
                            if (stuff_en) begin
                                r_run <= (rx_bit == r_prev) ? r_run + RunW'(1) : RunW'(1);
                            end
                            if (frame_end) begin
                                r_state  <= StReady;
                                bus_idle <= 1'b1;
                            end else if (!stuff_en) begin
                                r_state <= StNostuff;
                            end
                        end
                    end
                    StNostuff: begin
                        data_valid <= 1'b1;
                        data_bit   <= rx_bit;
                        if (frame_end) begin
                            r_state  <= StReady;
                            bus_idle <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= StInteg;
                        bus_idle <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CAN_DESTUFF_STATS_EN
    // Counters follow the registered pulses, so they settle one clk after each event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuff_cnt <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            if (sof) begin
                stuff_cnt <= 8'd0;
            end else if (remove_pulse && (stuff_cnt != 8'hFF)) begin
                stuff_cnt <= stuff_cnt + 8'd1;
            end
            if (stuff_error && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Directed, table-driven bench for can_destuff_ctrl (STUFF_LEN=5, IDLE_BITS=11).
module tb_can_destuff_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic sample_point, rx_bit, stuff_en, frame_end;
    logic data_valid, data_bit, sof, remove_pulse, stuff_error, bus_idle;
`ifdef CAN_DESTUFF_STATS_EN
    logic [7:0] stuff_cnt, err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic rx; logic en; logic fe;
        logic dv; logic bt; logic sf; logic rm; logic er; logic idle;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    can_destuff_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .stuff_en     (stuff_en),
        .frame_end    (frame_end),
        .data_valid   (data_valid),
        .data_bit     (data_bit),
        .sof          (sof),
        .remove_pulse (remove_pulse),
        .stuff_error  (stuff_error),
        .bus_idle     (bus_idle)
`ifdef CAN_DESTUFF_STATS_EN
        ,
        .stuff_cnt    (stuff_cnt),
        .err_cnt      (err_cnt)
`endif
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic push(input logic rx, input logic en, input logic fe, input logic dv,
                        input logic bt, input logic sf, input logic rm, input logic er,
                        input logic idle);
        vecs.push_back('{rx, en, fe, dv, bt, sf, rm, er, idle});
    endtask

    task automatic rep(input int n, input logic rx, input logic en, input logic dv,
                       input logic bt, input logic idle);
        for (int i = 0; i < n; i++) push(rx, en, 1'b0, dv, bt, 1'b0, 1'b0, 1'b0, idle);
    endtask

    // One sample_point strobe; returns at the negedge after the capturing posedge.
    task automatic apply(input logic rx, input logic en, input logic fe);
        @(negedge clk);
        sample_point = 1'b1;
        rx_bit       = rx;
        stuff_en     = en;
        frame_end    = fe;
        @(negedge clk);
        sample_point = 1'b0;
        frame_end    = 1'b0;
    endtask

    function automatic logic [5:0] outs();
        return {data_valid, data_bit, sof, remove_pulse, stuff_error, bus_idle};
    endfunction

    initial begin
        rst_n = 1'b0; sample_point = 1'b0; rx_bit = 1'b1; stuff_en = 1'b0; frame_end = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {2'b0, outs()}, 8'd0);
        rst_n = 1'b1;

        // Integration then first frame: stuff removal, unchecked bit, NOSTUFF, frame_end.
        rep(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 0, 0, 0, 1);
        push(0, 1, 0, 1, 0, 1, 0, 0, 0);
        rep(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1, 1, 0, 0, 0, 0, 1, 0, 0);
        rep(4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(1, 0, 0, 1, 1, 0, 0, 0, 0);
        rep(6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1, 1, 1, 1, 1, 0, 0, 0, 1);
        // Stuff error, silence in ERROR, recovery after 11 recessive samples.
        push(0, 1, 0, 1, 0, 1, 0, 0, 0);
        rep(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rep(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // frame_end on a stuff-position bit: no remove_pulse, back to READY.
        push(0, 1, 0, 1, 0, 1, 0, 0, 0);
        rep(5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(0, 1, 1, 0, 0, 0, 0, 0, 1);
        // Frame with three stuff bits.
        push(0, 1, 0, 1, 0, 1, 0, 0, 0);
        rep(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1, 1, 0, 0, 0, 0, 1, 0, 0);
        rep(4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(0, 1, 0, 0, 0, 0, 1, 0, 0);
        rep(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1, 1, 0, 0, 0, 0, 1, 0, 0);
        push(1, 1, 1, 1, 1, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [5:0] got, exp;
            v = vecs[i];
            apply(v.rx, v.en, v.fe);
            got = outs();
            if (!v.dv) got[4] = 1'b0;
            exp = {v.dv, v.dv & v.bt, v.sf, v.rm, v.er, v.idle};
            check($sformatf("vec%0d", i), {2'b0, got}, {2'b0, exp});
        end

        // Dominant level without a strobe must not start a frame.
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_no_strobe", {6'b0, sof, bus_idle}, 8'b01);

`ifdef CAN_DESTUFF_STATS_EN
        check("stuff_cnt_3", stuff_cnt, 8'd3);
        check("err_cnt_1", err_cnt, 8'd1);
`endif
        apply(1'b0, 1'b1, 1'b0);
        check("sof_after_hold", {7'b0, sof}, 8'd1);
        @(negedge clk);
`ifdef CAN_DESTUFF_STATS_EN
        check("stuff_cnt_clr", stuff_cnt, 8'd0);
`endif

        // Reset in mid-frame with a data bit strobed on the same edge.
        rst_n = 1'b0;
        apply(1'b0, 1'b1, 1'b0);
        check("midframe_reset", {2'b0, outs()}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b0);
        check("idle_after_10", {7'b0, bus_idle}, 8'd0);
        apply(1'b0, 1'b1, 1'b0);
        check("no_sof_in_integ", {6'b0, sof, data_valid}, 8'd0);
        for (int i = 0; i < 11; i++) apply(1'b1, 1'b0, 1'b0);
        check("idle_after_11", {7'b0, bus_idle}, 8'd1);
        apply(1'b0, 1'b1, 1'b0);
        check("sof_after_reset", {6'b0, sof, data_valid}, 8'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
